// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed 7-segment driver with a tear-free double-buffered frame load.
// Parameters: N_DIGITS digits (1..8); SCAN_DIV clk cycles each digit is driven (2..65535).
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-low
//   enable     - 1 = lit, 0 = outputs blanked while scanning keeps running
//   load_valid - new frame offered on load_data (5-bit glyph per digit, digit i at [5i+4:5i])
//   load_ready - shadow buffer free; a frame is accepted when load_valid && load_ready
//   anodes     - active-low digit select, bit i = digit i
//   cathodes   - active-low segments, bit0 = a ... bit6 = g
// Optional macro SEG_DP_EN adds load_dp (per-digit decimal point, loaded with load_data)
// and dp_n (active-low decimal point, registered alongside cathodes).
module seg_scan_display #(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 2500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load_valid,
  input  logic [5*N_DIGITS-1:0] load_data,
`ifdef SEG_DP_EN
  input  logic [N_DIGITS-1:0]   load_dp,
  output logic                  dp_n,
`endif
  output logic                  load_ready,
  output logic [N_DIGITS-1:0]   anodes,
  output logic [6:0]            cathodes
);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  logic [15:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic pend_q, pend_d;
  logic [5*N_DIGITS-1:0] shd_q, shd_d, act_q, act_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0] ca_q, ca_d;
  logic [4:0] code;
  logic tick, frame, xfer, commit;

  function automatic logic [6:0] decode(input logic [4:0] c);
    case (c)
      5'd0:  return 7'b1000000;
      5'd1:  return 7'b1111001;
      5'd2:  return 7'b0100100;
      5'd3:  return 7'b0110000;
      5'd4:  return 7'b0011001;
      5'd5:  return 7'b0010010;
      5'd6:  return 7'b0000010;
      5'd7:  return 7'b1111000;
      5'd8:  return 7'b0000000;
      5'd9:  return 7'b0010000;
      5'd10: return 7'b0001000;
      5'd11: return 7'b0000011;
      5'd12: return 7'b1000110;
      5'd13: return 7'b0100001;
      5'd14: return 7'b0000110;
      5'd15: return 7'b0001110;
      5'd16: return 7'b0001001;
      5'd17: return 7'b0001000;
      5'd18: return 7'b1000111;
      5'd19: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  assign tick = cnt_q == 16'(SCAN_DIV - 1);
  assign frame = tick && idx_q == IW'(N_DIGITS - 1);
  assign xfer = load_valid && !pend_q;
  // xfer needs pend_q = 0 and commit needs pend_q = 1, so a frame accepted on a
  // boundary cycle can only commit at the following boundary.
  assign commit = frame && pend_q;
  assign load_ready = !pend_q;
  assign anodes = an_q;
  assign cathodes = ca_q;

  // Outputs are loaded on the tick edge from the next index and next active buffer,
  // so a frame committed at the boundary is shown from its first digit onward.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 16'd1;
    idx_d = !tick ? idx_q : frame ? '0 : idx_q + IW'(1);
    pend_d = commit ? 1'b0 : xfer ? 1'b1 : pend_q;
    shd_d = xfer ? load_data : shd_q;
    act_d = commit ? shd_q : act_q;
    code = act_d[5*idx_d +: 5];
    an_d = !enable ? '1 : tick ? ~(N_DIGITS'(1) << idx_d) : an_q;
    ca_d = !enable ? '1 : tick ? decode(code) : ca_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      pend_q <= 1'b0;
      shd_q <= '1;
      act_q <= '1;
      an_q <= '1;
      ca_q <= '1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      shd_q <= shd_d;
      act_q <= act_d;
      an_q <= an_d;
      ca_q <= ca_d;
    end
  end

`ifdef SEG_DP_EN
  logic [N_DIGITS-1:0] dsh_q, dsh_d, dact_q, dact_d;
  logic dp_q, dp_d;

  always_comb begin
    dsh_d = xfer ? load_dp : dsh_q;
    dact_d = commit ? dsh_q : dact_q;
    dp_d = !enable ? 1'b1 : tick ? !dact_d[idx_d] : dp_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dsh_q <= '0;
      dact_q <= '0;
      dp_q <= 1'b1;
    end else begin
      dsh_q <= dsh_d;
      dact_q <= dact_d;
      dp_q <= dp_d;
    end
  end

  assign dp_n = dp_q;
`endif
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: self-checking bench for seg_scan_display (SCAN_DIV=4, N_DIGITS=4).
module tb_seg_scan_display;
  localparam int SD = 4;
  localparam int ND = 4;
  localparam logic [6:0] GLY [0:19] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                                        7'h09, 7'h08, 7'h47, 7'h3F};
  localparam logic [3:0] AN_TBL [0:4] = '{4'hf, 4'hd, 4'hb, 4'h7, 4'he};

  logic clk = 1'b0;
  logic reset, enable, load_valid, load_ready;
  logic [5*ND-1:0] load_data;
  logic [ND-1:0] anodes;
  logic [6:0] cathodes;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef SEG_DP_EN
  logic [ND-1:0] load_dp;
  logic dp_n;
  seg_scan_display #(.N_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid), .load_data(load_data),
    .load_dp(load_dp), .dp_n(dp_n), .load_ready(load_ready), .anodes(anodes), .cathodes(cathodes));
`else
  seg_scan_display #(.N_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .anodes(anodes), .cathodes(cathodes));
`endif

  // Reference model: k counts rising edges since reset release. Edge e is a tick when
  // e is a multiple of SD, a frame boundary when a multiple of SD*ND, and the digit shown
  // after it is (e/SD) mod ND.
  function automatic bit is_tick(int unsigned e); return e % SD == 0; endfunction
  function automatic bit is_fb(int unsigned e); return e % (SD * ND) == 0; endfunction
  function automatic int digit(int unsigned e); return int'((e / SD) % ND); endfunction
  function automatic logic [6:0] seg_of(logic [5*ND-1:0] f, int d);
    logic [4:0] c;
    c = f[5*d +: 5];
    return c < 5'd20 ? GLY[c] : 7'h7f;
  endfunction

  int unsigned k;
  logic m_pend;
  logic [5*ND-1:0] m_sh, m_act;
  logic [ND-1:0] m_an;
  logic [6:0] m_ca;
  wire m_cm = m_pend && is_fb(k + 1);
  wire [5*ND-1:0] m_vis = m_cm ? m_sh : m_act;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k <= 0; m_pend <= 1'b0; m_sh <= '1; m_act <= '1; m_an <= '1; m_ca <= '1;
    end else begin
      k <= k + 1;
      if (m_cm) begin m_act <= m_sh; m_pend <= 1'b0; end
      else if (load_valid && !m_pend) begin m_sh <= load_data; m_pend <= 1'b1; end
      if (!enable) begin m_an <= '1; m_ca <= '1; end
      else if (is_tick(k + 1)) begin
        m_an <= ~(4'b0001 << digit(k + 1));
        m_ca <= seg_of(m_vis, digit(k + 1));
      end
    end
  end

`ifdef SEG_DP_EN
  logic [ND-1:0] m_dsh, m_dact;
  logic m_dp;
  wire [ND-1:0] m_dvis = m_cm ? m_dsh : m_dact;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_dsh <= '0; m_dact <= '0; m_dp <= 1'b1;
    end else begin
      if (m_cm) m_dact <= m_dsh;
      else if (load_valid && !m_pend) m_dsh <= load_dp;
      if (!enable) m_dp <= 1'b1;
      else if (is_tick(k + 1)) m_dp <= !m_dvis[digit(k + 1)];
    end
  end
`endif

  task automatic test_reset;
    reset = 1'b0; enable = 1'b1; load_valid = 1'b0; load_data = '0;
`ifdef SEG_DP_EN
    load_dp = '0;
`endif
    repeat (3) @(negedge clk);
    n_chk++; if (anodes !== 4'hf) begin n_fail++; $display("FAIL reset_anodes: got %b expected 1111", anodes); end
    n_chk++; if (cathodes !== 7'h7f) begin n_fail++; $display("FAIL reset_cathodes: got %b expected 1111111", cathodes); end
    n_chk++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", load_ready); end
    reset = 1'b1;
  endtask

  task automatic test_scan;
    for (int e = 0; e < 20; e++) begin
      n_chk++; if (anodes !== AN_TBL[e / 4]) begin n_fail++; $display("FAIL scan_anodes k=%0d: got %b expected %b", e, anodes, AN_TBL[e / 4]); end
      n_chk++; if (cathodes !== 7'h7f) begin n_fail++; $display("FAIL scan_cathodes k=%0d: got %b expected 1111111", e, cathodes); end
      @(negedge clk);
    end
  endtask

  task automatic test_load;
    load_valid = 1'b1;
    load_data = {5'd17, 5'd19, 5'd19, 5'd1};
    @(negedge clk);
    load_valid = 1'b0;
    n_chk++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_drop: got %b expected 0", load_ready); end
    for (int i = 0; i < 27; i++) begin
      n_chk++; if (anodes !== m_an || cathodes !== m_ca || load_ready !== !m_pend) begin
        n_fail++; $display("FAIL load_model k=%0d: got %b/%b/%b expected %b/%b/%b", k, anodes, cathodes, load_ready, m_an, m_ca, !m_pend); end
      if (k < 32) begin n_chk++; if (cathodes !== 7'h7f) begin n_fail++; $display("FAIL load_old_frame k=%0d: got %b expected 1111111", k, cathodes); end end
      if (k == 32) begin n_chk++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_return: got %b expected 1", load_ready); end end
      if (k >= 32 && k < 36) begin n_chk++; if (cathodes !== 7'b1111001 || anodes !== 4'b1110) begin n_fail++; $display("FAIL load_digit0 k=%0d: got %b/%b expected 1110/1111001", k, anodes, cathodes); end end
      if (k >= 44) begin n_chk++; if (cathodes !== 7'b0001000 || anodes !== 4'b0111) begin n_fail++; $display("FAIL load_digit3 k=%0d: got %b/%b expected 0111/0001000", k, anodes, cathodes); end end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    load_valid = 1'b1;
    load_data = '0;
    @(negedge clk);
    load_data = {4{5'd7}};
    n_chk++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready: got %b expected 0", load_ready); end
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      n_chk++; if (anodes !== m_an || cathodes !== m_ca) begin n_fail++; $display("FAIL b2b_model k=%0d: got %b/%b expected %b/%b", k, anodes, cathodes, m_an, m_ca); end
      if (k >= 64) begin n_chk++; if (cathodes !== 7'h40) begin n_fail++; $display("FAIL b2b_zero k=%0d: got %b expected 1000000", k, cathodes); end end
      @(negedge clk);
    end
  endtask

  task automatic test_enable;
    repeat (8) @(negedge clk);
    n_chk++; if (anodes !== 4'b1011) begin n_fail++; $display("FAIL en_digit2: got %b expected 1011", anodes); end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (anodes !== 4'hf || cathodes !== 7'h7f) begin n_fail++; $display("FAIL en_blank k=%0d: got %b/%b expected 1111/1111111", k, anodes, cathodes); end
    end
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++; if (anodes !== (k < 96 ? 4'b0111 : 4'b1110) || cathodes !== 7'h40) begin
        n_fail++; $display("FAIL en_resume k=%0d: got %b/%b expected %b/1000000", k, anodes, cathodes, k < 96 ? 4'b0111 : 4'b1110); end
    end
  endtask

  task automatic test_reset_pending;
    load_valid = 1'b1;
    load_data = 20'($urandom) & 20'h7bdef;
    @(negedge clk);
    load_valid = 1'b0;
    n_chk++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL rstp_pending: got %b expected 0", load_ready); end
    #2 reset = 1'b0;
    #1;
    n_chk++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL rstp_ready_async: got %b expected 1", load_ready); end
    n_chk++; if (anodes !== 4'hf || cathodes !== 7'h7f) begin n_fail++; $display("FAIL rstp_blank_async: got %b/%b expected 1111/1111111", anodes, cathodes); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_chk++; if (cathodes !== 7'h7f || load_ready !== 1'b1 || anodes !== m_an) begin
        n_fail++; $display("FAIL rstp_no_commit k=%0d: got %b/%b/%b expected %b/1111111/1", k, anodes, cathodes, load_ready, m_an); end
    end
  endtask

`ifdef SEG_DP_EN
  task automatic test_dp;
    load_valid = 1'b1;
    load_dp = 4'b0100;
    load_data = {4{5'd8}};
    @(negedge clk);
    load_valid = 1'b0;
    load_dp = '0;
    repeat (2 * SD * ND) @(negedge clk);
    for (int i = 0; i < SD * ND; i++) begin
      n_chk++; if (dp_n !== (anodes === 4'b1011 ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL dp_digit2 k=%0d: got %b with anodes %b", k, dp_n, anodes); end
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      n_chk++; if (anodes !== m_an || cathodes !== m_ca || load_ready !== !m_pend) begin
        n_fail++; $display("FAIL rand k=%0d: got %b/%b/%b expected %b/%b/%b", k, anodes, cathodes, load_ready, m_an, m_ca, !m_pend); end
`ifdef SEG_DP_EN
      n_chk++; if (dp_n !== m_dp) begin n_fail++; $display("FAIL rand_dp k=%0d: got %b expected %b", k, dp_n, m_dp); end
      load_dp = 4'($urandom);
`endif
      enable = $urandom_range(0, 9) != 0;
      load_valid = $urandom_range(0, 3) == 0;
      load_data = 20'($urandom);
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_scan;
    test_load;
    test_back_to_back;
    test_enable;
    test_reset_pending;
`ifdef SEG_DP_EN
    test_dp;
`endif
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
